serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 101 ++++++++++
 tb/tb_serial_adder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one 1-bit full adder, LSB first; optional ovf port via SERIAL_ADDER_OVF_EN.
// Latency: done pulses WIDTH cycles after the edge that samples start; start in DONE restarts at once.
// Backpressure: none; start is ignored while busy, sum/cout hold until the next done.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr, b_sr, work, work_nxt;
   logic             carry, s_bit, c_nxt, last_bit, accept;

   assign accept   = start && (state != RUN);
   assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));
   assign s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
   assign c_nxt    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

   // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
   generate
      if (WIDTH == 1) begin : g_w1
         assign work_nxt = s_bit;
      end else begin : g_wn
         assign work_nxt = {s_bit, work[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         work  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (accept) begin
         a_sr  <= a;
         b_sr  <= b;
         carry <= cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         carry <= c_nxt;
         work  <= work_nxt;
         cnt   <= last_bit ? '0 : cnt + CW'(1);
         if (last_bit) begin
            sum  <= work_nxt;
            cout <= c_nxt;
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   // Carry into the MSB is the carry flop while the last bit is being added.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ovf <= 1'b0;
      else if (last_bit) ovf <= carry ^ c_nxt;
   end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): expected {ovf,cout,sum} queued at start, checked on done.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n, start, cin;
   logic [7:0] a, b;
   logic       busy, done, cout;
   logic [7:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf;
`endif

   int         n_chk = 0;
   int         n_fail = 0;
   int         done_cnt = 0;
   logic [9:0] sb[$];
   logic [9:0] last_res = '0;

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic ci);
      logic [8:0] t;
      logic       ov;
      t  = {1'b0, x} + {1'b0, y} + {8'd0, ci};
      ov = (x[7] == y[7]) && (t[7] != x[7]);
      return {ov, t};
   endfunction

   // Scoreboard side: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         done_cnt++;
         if (sb.size() == 0) begin
            chk("sb_unexpected_done", 32'd1, 32'd0);
         end else begin
            last_res = sb.pop_front();
            chk("sb_sum", {24'd0, sum}, {24'd0, last_res[7:0]});
            chk("sb_cout", {31'd0, cout}, {31'd0, last_res[8]});
`ifdef SERIAL_ADDER_OVF_EN
            chk("sb_ovf", {31'd0, ovf}, {31'd0, last_res[9]});
`endif
         end
      end
   end

   task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic ci);
      a = x; b = y; cin = ci; start = 1'b1;
      sb.push_back(model(x, y, ci));
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!done && cyc < 40);
      if (!done) chk("done_timeout", 32'd0, 32'd1);
   endtask

   // One isolated addition with a cycle-by-cycle busy/done/hold check.
   task automatic run_add(input logic [7:0] x, input logic [7:0] y, input logic ci);
      logic [9:0] prev;
      prev = last_res;
      @(negedge clk);
      drive(x, y, ci);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
         end
         chk("run_busy", {31'd0, busy}, 32'd1);
         chk("run_done", {31'd0, done}, 32'd0);
         if (k == 4) chk("run_sum_hold", {24'd0, sum}, {24'd0, prev[7:0]});
      end
      @(negedge clk);
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("done_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("done_single", {31'd0, done}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int cyc, d0;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sum", {24'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_add(8'hFF, 8'h01, 1'b0);
      chk("ff01_sum", {24'd0, sum}, 32'h00);
      chk("ff01_cout", {31'd0, cout}, 32'd1);
      run_add(8'h00, 8'h00, 1'b1);
      chk("0001_sum", {24'd0, sum}, 32'h01);
      chk("0001_cout", {31'd0, cout}, 32'd0);
      run_add(8'h7F, 8'h01, 1'b0);
      chk("7f01_sum", {24'd0, sum}, 32'h80);
      run_add(8'h80, 8'h80, 1'b1);
      for (int i = 0; i < 4; i++)
         run_add(8'($urandom), 8'($urandom), 1'($urandom));

      // Restart attempt 3 cycles into RUN must be ignored.
      d0 = done_cnt;
      @(negedge clk);
      drive(8'h12, 8'h34, 1'b0);
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); a = 8'hAA; b = 8'h77; cin = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_done(cyc);
      chk("repulse_latency", cyc, 32'd5);
      repeat (15) @(negedge clk);
      chk("repulse_one_done", done_cnt - d0, 32'd1);

      // Reset 4 cycles into RUN aborts with no done.
      @(negedge clk);
      drive(8'h55, 8'h22, 1'b0);
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_sum", {24'd0, sum}, 32'd0);
      chk("arst_cout", {31'd0, cout}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      sb.delete();
      last_res = '0;
      d0 = done_cnt;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("arst_no_done", done_cnt - d0, 32'd0);
      run_add(8'h3C, 8'h0F, 1'b0);
      chk("3c0f_sum", {24'd0, sum}, 32'h4B);

      // Back-to-back with start held high, operands refreshed in each DONE cycle.
      @(negedge clk);
      drive(8'($urandom), 8'($urandom), 1'($urandom));
      for (int i = 0; i < 4; i++) begin
         wait_done(cyc);
         chk("b2b_period", cyc, 32'd9);
         if (i < 3) drive(8'($urandom), 8'($urandom), 1'($urandom));
         else start = 1'b0;
      end
      @(negedge clk);
      chk("b2b_idle", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      chk("sb_drain", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
